// File: rtl/jpeg_frame_sequencer.sv
// Frame-level controller for jpeg_decoder: gates bits, soft-resets, counts rows/blocks, writes framebuffer.
// Optional block-alignment check enabled by defining JPEG_SEQ_ALIGN_CHECK_EN.
module jpeg_frame_sequencer #(
  parameter int WIDTH_BLK  = 40,
  parameter int HEIGHT_BLK = 30,
  parameter int ADDR_W     = 14
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic              src_bit_in,
  input  logic              src_valid_in,
  output logic              src_ready_out,
  output logic              dec_rst_out,
  output logic              dec_serial_out,
  output logic              dec_valid_out,
  input  logic [63:0]       dec_row_in,
  input  logic              dec_valid_in,
  input  logic              dec_final_in,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [63:0]       fb_data_out,
  output logic              fb_we_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              error_out
);

  localparam int BX_W = (WIDTH_BLK > 1) ? $clog2(WIDTH_BLK) : 1;
  localparam int BY_W = (HEIGHT_BLK > 1) ? $clog2(HEIGHT_BLK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t            state, state_nx;
  logic              to_run_q, to_run_nx;
  logic [2:0]        row_q, row_nx;
  logic [BX_W-1:0]   bx_q, bx_nx;
  logic [BY_W-1:0]   by_q, by_nx;
  logic              err_q, err_nx;
  logic              accept;
  logic              row_last;
  logic              bx_last;
  logic              by_last;
  logic              blk_adv;
  logic              bad_align;
  logic [ADDR_W-1:0] addr_c;

  // abort wins over a row arriving in the same cycle
  assign accept   = (state == RUN) & dec_valid_in & ~abort_in;
  assign row_last = (row_q == 3'd7);
  assign bx_last  = (bx_q == BX_W'(WIDTH_BLK - 1));
  assign by_last  = (by_q == BY_W'(HEIGHT_BLK - 1));

`ifdef JPEG_SEQ_ALIGN_CHECK_EN
  assign blk_adv   = row_last | dec_final_in;
  assign bad_align = dec_final_in ^ row_last;
`else
  logic unused_final;
  assign unused_final = dec_final_in;
  assign blk_adv      = row_last;
  assign bad_align    = 1'b0;
`endif

  assign addr_c = ((ADDR_W'(by_q) << 3) + ADDR_W'(row_q))
                * ADDR_W'(WIDTH_BLK) + ADDR_W'(bx_q);

  assign src_ready_out  = (state == RUN);
  assign dec_serial_out = src_bit_in;
  assign dec_valid_out  = src_valid_in & src_ready_out;
  assign dec_rst_out    = rst_in | (state == CLEAR);
  assign busy_out       = (state != IDLE);
  assign frame_done_out = (state == DONE);
  assign error_out      = err_q;

  // next state and row/block counters
  always_comb begin
    state_nx  = state;
    to_run_nx = to_run_q;
    row_nx    = row_q;
    bx_nx     = bx_q;
    by_nx     = by_q;
    err_nx    = err_q;
    unique case (state)
      IDLE: begin
        if (start_in) begin
          state_nx  = CLEAR;
          to_run_nx = 1'b1;
        end
      end
      CLEAR: begin
        row_nx   = '0;
        bx_nx    = '0;
        by_nx    = '0;
        err_nx   = 1'b0;
        state_nx = to_run_q ? RUN : IDLE;
      end
      RUN: begin
        if (abort_in) begin
          state_nx  = CLEAR;
          to_run_nx = 1'b0;
        end else if (accept) begin
          if (bad_align) err_nx = 1'b1;
          if (blk_adv) begin
            row_nx = '0;
            if (bx_last) begin
              bx_nx = '0;
              if (by_last) state_nx = DONE;
              else by_nx = by_q + 1'b1;
            end else begin
              bx_nx = bx_q + 1'b1;
            end
          end else begin
            row_nx = row_q + 3'd1;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state, counters and the one-cycle-late framebuffer write port
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      to_run_q    <= 1'b0;
      row_q       <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      err_q       <= 1'b0;
      fb_we_out   <= 1'b0;
      fb_addr_out <= '0;
      fb_data_out <= '0;
    end else begin
      state     <= state_nx;
      to_run_q  <= to_run_nx;
      row_q     <= row_nx;
      bx_q      <= bx_nx;
      by_q      <= by_nx;
      err_q     <= err_nx;
      fb_we_out <= accept;
      if (accept) begin
        fb_addr_out <= addr_c;
        fb_data_out <= dec_row_in;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_frame_sequencer.sv
// Bench for jpeg_frame_sequencer: directed table, hand sequences, random frames vs a reference model.
module tb_jpeg_frame_sequencer;

  localparam int W  = 3;
  localparam int H  = 2;
  localparam int AW = 8;

  logic          clk_in = 1'b0;
  logic          rst_in, start_in, abort_in;
  logic          src_bit_in, src_valid_in;
  logic          src_ready_out, dec_rst_out;
  logic          dec_serial_out, dec_valid_out;
  logic [63:0]   dec_row_in;
  logic          dec_valid_in, dec_final_in;
  logic [AW-1:0] fb_addr_out;
  logic [63:0]   fb_data_out;
  logic          fb_we_out, busy_out;
  logic          frame_done_out, error_out;

  jpeg_frame_sequencer #(
    .WIDTH_BLK(W), .HEIGHT_BLK(H), .ADDR_W(AW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .start_in(start_in), .abort_in(abort_in),
    .src_bit_in(src_bit_in), .src_valid_in(src_valid_in),
    .src_ready_out(src_ready_out), .dec_rst_out(dec_rst_out),
    .dec_serial_out(dec_serial_out), .dec_valid_out(dec_valid_out),
    .dec_row_in(dec_row_in), .dec_valid_in(dec_valid_in),
    .dec_final_in(dec_final_in), .fb_addr_out(fb_addr_out),
    .fb_data_out(fb_data_out), .fb_we_out(fb_we_out),
    .busy_out(busy_out), .frame_done_out(frame_done_out),
    .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  task automatic chk1(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk64(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: frame progress as a row-in-block index plus a raster block index
  typedef enum {M_IDLE, M_CLEAR, M_RUN, M_DONE} mmode_t;
  mmode_t      m_mode = M_IDLE;
  bit          m_to_run = 1'b0;
  int          m_r = 0;
  int          m_blk = 0;
  bit          m_we = 1'b0;
  bit          m_err = 1'b0;
  int          m_addr = 0;
  logic [63:0] m_data = '0;

  task automatic model_next();
    bit adv;
    if (rst_in) begin
      m_mode = M_IDLE; m_to_run = 0;
      m_r = 0; m_blk = 0;
      m_we = 0; m_err = 0;
      m_addr = 0; m_data = '0;
      return;
    end
    m_we = 0;
    case (m_mode)
      M_IDLE: if (start_in) begin
        m_mode = M_CLEAR; m_to_run = 1;
      end
      M_CLEAR: begin
        m_r = 0; m_blk = 0; m_err = 0;
        m_mode = m_to_run ? M_RUN : M_IDLE;
      end
      M_RUN: begin
        if (abort_in) begin
          m_mode = M_CLEAR; m_to_run = 0;
        end else if (dec_valid_in) begin
          m_addr = ((m_blk / W) * 8 + m_r) * W + (m_blk % W);
          m_data = dec_row_in;
          m_we = 1;
          adv = (m_r == 7);
`ifdef JPEG_SEQ_ALIGN_CHECK_EN
          if (dec_final_in != (m_r == 7)) m_err = 1;
          adv = adv | dec_final_in;
`endif
          if (adv) begin
            m_r = 0; m_blk++;
          end else begin
            m_r++;
          end
          if (m_blk == W * H) m_mode = M_DONE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // one clock: check combinational outputs, step model, check registered outputs
  task automatic cycle();
    #1;
    chk1("src_ready", src_ready_out, m_mode == M_RUN);
    chk1("dec_valid", dec_valid_out, src_valid_in && m_mode == M_RUN);
    chk1("dec_serial", dec_serial_out, src_bit_in);
    chk1("dec_rst", dec_rst_out, rst_in || m_mode == M_CLEAR);
    chk1("busy", busy_out, m_mode != M_IDLE);
    chk1("frame_done", frame_done_out, m_mode == M_DONE);
    chk1("error", error_out, m_err);
    model_next();
    @(negedge clk_in);
    chk1("fb_we", fb_we_out, m_we);
    if (m_we) begin
      chk64("fb_addr", 64'(fb_addr_out), 64'(m_addr));
      chk64("fb_data", fb_data_out, m_data);
    end
    if (frame_done_out) done_cnt++;
  endtask

  task automatic idle_in();
    start_in = 0; abort_in = 0;
    src_bit_in = 0; src_valid_in = 0;
    dec_valid_in = 0; dec_final_in = 0;
    dec_row_in = '0;
  endtask

  task automatic rows(int n);
    for (int k = 0; k < n; k++) begin
      dec_valid_in = 1;
      dec_row_in = {$urandom, $urandom};
      dec_final_in = (m_r == 7);
      src_valid_in = 1'($urandom);
      src_bit_in = 1'($urandom);
      cycle();
    end
    idle_in();
  endtask

  task automatic start_frame();
    idle_in();
    start_in = 1;
    cycle();
    start_in = 0;
    cycle();
  endtask

  typedef struct {
    logic        start, abort, dval, sval, sbit;
    logic [63:0] row;
    logic        e_ready, e_dvo, e_decrst, e_we, e_busy;
    logic [7:0]  e_addr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int d0;
    bit seen;
    tbl[0] = '{0,0,1,1,1, 64'hA0, 0,0,0,0,0, 8'd0};
    tbl[1] = '{1,0,0,0,0, 64'h0,  0,0,0,0,1, 8'd0};
    tbl[2] = '{0,0,0,1,0, 64'h0,  0,0,1,0,1, 8'd0};
    tbl[3] = '{0,0,1,1,1, 64'hA3, 1,1,0,1,1, 8'd0};
    tbl[4] = '{1,0,1,0,0, 64'hA4, 1,0,0,1,1, 8'd3};
    tbl[5] = '{0,0,0,1,1, 64'h0,  1,1,0,0,1, 8'd0};
    tbl[6] = '{0,0,1,0,0, 64'hA6, 1,0,0,1,1, 8'd6};

    idle_in();
    rst_in = 1;
    @(posedge clk_in);
    @(negedge clk_in);
    src_valid_in = 1;
    src_bit_in = 1;
    cycle();
    cycle();
    chk64("rst_addr", 64'(fb_addr_out), 64'd0);
    chk64("rst_data", fb_data_out, 64'd0);
    rst_in = 0;
    idle_in();

    foreach (tbl[i]) begin
      start_in = tbl[i].start;
      abort_in = tbl[i].abort;
      dec_valid_in = tbl[i].dval;
      src_valid_in = tbl[i].sval;
      src_bit_in = tbl[i].sbit;
      dec_row_in = tbl[i].row;
      dec_final_in = 0;
      #1;
      chk1("tbl_ready", src_ready_out, tbl[i].e_ready);
      chk1("tbl_dvo", dec_valid_out, tbl[i].e_dvo);
      chk1("tbl_decrst", dec_rst_out, tbl[i].e_decrst);
      cycle();
      chk1("tbl_we", fb_we_out, tbl[i].e_we);
      chk1("tbl_busy", busy_out, tbl[i].e_busy);
      if (tbl[i].e_we) begin
        chk64("tbl_addr", 64'(fb_addr_out), 64'(tbl[i].e_addr));
        chk64("tbl_data", fb_data_out, tbl[i].row);
      end
    end
    idle_in();

    // abort after five rows, then restart from address 0
    rows(2);
    abort_in = 1;
    dec_valid_in = 1;
    dec_row_in = 64'hDEAD;
    cycle();
    chk1("abort_we", fb_we_out, 1'b0);
    idle_in();
    #1;
    chk1("abort_clear_rst", dec_rst_out, 1'b1);
    cycle();
    chk1("abort_idle", busy_out, 1'b0);
    chk64("abort_no_done", 64'(done_cnt), 64'd0);
    start_frame();
    rows(1);
    chk64("restart_addr", 64'(fb_addr_out), 64'd0);
    abort_in = 1;
    cycle();
    idle_in();
    cycle();

    // random traffic over a full frame
    for (int f = 0; f < 2; f++) begin
      d0 = done_cnt;
      seen = 0;
      start_in = 1;
      cycle();
      for (int i = 0; i < 3000; i++) begin
        start_in = ($urandom_range(0, 7) == 0);
        dec_valid_in = ($urandom_range(0, 3) != 0);
        dec_row_in = {$urandom, $urandom};
        dec_final_in = ($urandom_range(0, 15) == 0);
        src_valid_in = 1'($urandom);
        src_bit_in = 1'($urandom);
        cycle();
        if (m_mode == M_DONE) seen = 1;
        if (seen && m_mode == M_IDLE) break;
      end
      chk64("rand_done_pulses", 64'(done_cnt - d0), 64'd1);
      idle_in();
    end

    // back-to-back rows every cycle, rows in DONE/IDLE dropped
    d0 = done_cnt;
    seen = 0;
    start_frame();
    for (int i = 0; i < 200; i++) begin
      dec_valid_in = 1;
      dec_row_in = {$urandom, $urandom};
      dec_final_in = (m_r == 7);
      cycle();
      if (m_mode == M_DONE) seen = 1;
      if (seen && m_mode == M_IDLE) break;
    end
    cycle();
    chk1("idle_drop_we", fb_we_out, 1'b0);
    chk64("b2b_done_pulses", 64'(done_cnt - d0), 64'd1);
    idle_in();

    // abort coinciding with the final row of the frame
    d0 = done_cnt;
    start_frame();
    rows(W * H * 8 - 1);
    abort_in = 1;
    dec_valid_in = 1;
    dec_final_in = 1;
    cycle();
    chk1("abort_last_we", fb_we_out, 1'b0);
    idle_in();
    cycle();
    cycle();
    chk64("abort_last_done", 64'(done_cnt - d0), 64'd0);

    // reset mid-frame discards the in-flight write
    start_frame();
    rows(10);
    rst_in = 1;
    dec_valid_in = 1;
    cycle();
    chk1("rst_mid_we", fb_we_out, 1'b0);
    chk1("rst_mid_busy", busy_out, 1'b0);
    rst_in = 0;
    idle_in();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
